vga_draw_scheduler: RTL and testbench

Sequences shared access to the VGA plot path between the five screen drawers: background, pac-man sprite, win screen, game-over screen and exit screen. Each drawer requests the path. The scheduler grants exactly one drawer at a time, drives the 3-bit source select of the VGA source mux, and gates the adapter's plot enable. It holds the grant until the owner signals completion.

---
 rtl/vga_draw_pkg.sv | 31 +++
 rtl/vga_draw_scheduler_if.sv | 31 +++
 rtl/vga_draw_scheduler_picker.sv | 36 +++
 rtl/vga_draw_scheduler.sv | 132 +++++++++++++
 tb/tb_vga_draw_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_draw_pkg.sv
// ============================================================================
// Module : vga_draw_pkg
// Brief  : Source codes, state encoding and helpers shared by the draw scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_draw_pkg;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] SRC_BG       = 3'd0;
    localparam logic [2:0] SRC_PACMAN   = 3'd1;
    localparam logic [2:0] SRC_WIN      = 3'd2;
    localparam logic [2:0] SRC_GAMEOVER = 3'd3;
    localparam logic [2:0] SRC_EXIT     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_DRAW    = 2'd2,
        ST_RELEASE = 2'd3
    } draw_state_t;

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [2:0] idx);
        src_onehot = NUM_SRC'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_draw_scheduler_if.sv
// ============================================================================
// Module : vga_draw_scheduler_if
// Brief  : Request/grant bundle between the screen drawers and the scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vga_draw_scheduler_if;
    import vga_draw_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] done;
    logic [NUM_SRC-1:0] grant;
    logic [2:0]         mux_select;
    logic               plot;
    logic               busy;
    logic               draw_timeout;

    modport master (
        output req, done,
        input  grant, mux_select, plot, busy, draw_timeout
    );

    modport slave (
        input  req, done,
        output grant, mux_select, plot, busy, draw_timeout
    );

endinterface

`default_nettype wire

// File: rtl/vga_draw_scheduler_picker.sv
// ============================================================================
// Module : draw_src_picker
// Brief  : Fixed priority for exit/gameover/win, round-robin between bg and pacman.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module draw_src_picker
    import vga_draw_pkg::*;
(
    input  wire logic [NUM_SRC-1:0] i_req,
    input  wire logic               i_rr_ptr,
    output logic                    o_valid,
    output logic [2:0]              o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = SRC_BG;
        if (i_req[SRC_EXIT]) begin
            o_idx = SRC_EXIT;
        end else if (i_req[SRC_GAMEOVER]) begin
            o_idx = SRC_GAMEOVER;
        end else if (i_req[SRC_WIN]) begin
            o_idx = SRC_WIN;
        end else if (i_req[SRC_BG] && i_req[SRC_PACMAN]) begin
            // Pointer only matters when both background-class drawers compete
            o_idx = i_rr_ptr ? SRC_PACMAN : SRC_BG;
        end else if (i_req[SRC_PACMAN]) begin
            o_idx = SRC_PACMAN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_draw_scheduler.sv
// ============================================================================
// Module : vga_draw_scheduler
// Brief  : Grants the VGA plot path to one drawer at a time; optional watchdog
//          compiled in with DRAW_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_draw_scheduler
    import vga_draw_pkg::*;
#(
    parameter int MAX_DRAW_CYCLES = 19200
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    vga_draw_scheduler_if.slave bus
);

    draw_state_t        r_state;
    draw_state_t        w_state_nxt;
    logic [NUM_SRC-1:0] r_grant;
    logic [2:0]         r_mux;
    logic               r_plot;
    logic               r_busy;
    logic               r_timeout;
    logic               r_rr_ptr;
    logic               w_timeout_nxt;
    logic               w_pick_valid;
    logic [2:0]         w_pick_idx;
    logic               w_owner_done;
    logic               w_wd_expire;

    draw_src_picker u_picker (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_owner_done = bus.done[r_mux];

`ifdef DRAW_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_DRAW_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;

    // Counter holds DRAW cycles already completed, so it hits LIMIT-1 on the last allowed one
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_DRAW) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_wd_expire = (r_state == ST_DRAW) && (r_wd_cnt == CNT_W'(MAX_DRAW_CYCLES - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_DRAW_CYCLES > 0);
    assign w_wd_expire  = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                if (w_owner_done) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_wd_expire) begin
                    w_state_nxt   = ST_RELEASE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_grant   <= '0;
            r_mux     <= SRC_BG;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_rr_ptr  <= 1'b0;
        end else begin
            r_plot    <= (w_state_nxt == ST_DRAW);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_timeout <= w_timeout_nxt;
            if (r_state == ST_IDLE && w_pick_valid) begin
                r_grant <= src_onehot(w_pick_idx);
                r_mux   <= w_pick_idx;
                if (w_pick_idx == SRC_BG) begin
                    r_rr_ptr <= 1'b1;
                end else if (w_pick_idx == SRC_PACMAN) begin
                    r_rr_ptr <= 1'b0;
                end
            end else if (w_state_nxt == ST_RELEASE) begin
                r_grant <= '0;
            end
        end
    end

    assign bus.grant        = r_grant;
    assign bus.mux_select   = r_mux;
    assign bus.plot         = r_plot;
    assign bus.busy         = r_busy;
    assign bus.draw_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_vga_draw_scheduler.sv
// ============================================================================
// Module : tb_vga_draw_scheduler
// Brief  : Randomised drawer batches against a reference arbitration model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_draw_scheduler;

    localparam int c_MAX     = 8;
    localparam int c_BATCHES = 60;

    typedef struct {
        int idx;
        int plot_n;
        bit to;
        int t_req;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    bit   mon_on;
    bit   m_rr_pac;
    int   dcnt;
    int   len [5];
    int   last_rel;
    exp_t q [$];

    vga_draw_scheduler_if bus ();

    vga_draw_scheduler #(
        .MAX_DRAW_CYCLES (c_MAX)
    ) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL global_timeout simulation did not finish bad=%0d", bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arbitration: highest of exit/gameover/win, else alternate bg/pacman
    task automatic model_pick(input logic [4:0] pend, output int idx);
        idx = -1;
        for (int s = 4; s >= 2; s--) begin
            if (idx < 0 && pend[s]) idx = s;
        end
        if (idx < 0) begin
            if (pend[0] && pend[1]) idx = m_rr_pac ? 1 : 0;
            else if (pend[1])       idx = 1;
            else                    idx = 0;
            m_rr_pac = (idx == 0);
        end
    endtask

    // One clock of drawer behaviour: drop req on grant, pulse done after len DRAW cycles
    task automatic tick();
        int         own;
        logic [4:0] s;
        @(posedge clk);
        #1;
        own = -1;
        for (int i = 0; i < 5; i++) begin
            if (bus.grant[i]) begin
                own        = i;
                bus.req[i] = 1'b0;
            end
        end
        bus.done = '0;
        if (own < 0) begin
            dcnt = 0;
        end else if (bus.plot) begin
            dcnt++;
            if (dcnt == len[own]) bus.done[own] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
            s        = 5'(1) << $urandom_range(0, 4);
            bus.done = bus.done | (s & ~bus.grant);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(bus.req == '0 && !bus.busy && bus.grant == '0 && q.size() == 0) && g < 3000) begin
            tick();
            g++;
        end
        if (g >= 3000) chk("wait_idle_bound", 32'(g), 32'd0);
    endtask

    // Monitor: every grant pops one expected transaction and checks its whole life
    initial begin
        exp_t e;
        int   n;
        int   guard;
        forever begin
            @(negedge clk);
            if (mon_on && bus.grant != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.grant), 32'd0);
                    guard = 0;
                    while (bus.grant != '0 && guard < 2000) begin
                        @(negedge clk);
                        guard++;
                    end
                end else begin
                    e = q.pop_front();
                    chk("grant_onehot", 32'(bus.grant), 32'(1) << e.idx);
                    chk("mux_select", 32'(bus.mux_select), 32'(e.idx));
                    chk("settle_plot", 32'(bus.plot), 32'd0);
                    chk("settle_busy", 32'(bus.busy), 32'd1);
                    if (e.t_req >= 0) chk("grant_latency", 32'(cyc - e.t_req), 32'd1);
                    else              chk("grant_spacing", 32'(cyc - last_rel), 32'd2);
                    n     = 0;
                    guard = 0;
                    @(negedge clk);
                    while (bus.grant != '0 && guard < 2000) begin
                        if (bus.plot) n++;
                        chk("timeout_during_draw", 32'(bus.draw_timeout), 32'd0);
                        guard++;
                        @(negedge clk);
                    end
                    if (guard >= 2000) chk("release_bound", 32'(guard), 32'd0);
                    last_rel = cyc;
                    chk("plot_cycles", 32'(n), 32'(e.plot_n));
                    chk("release_plot", 32'(bus.plot), 32'd0);
                    chk("release_busy", 32'(bus.busy), 32'd1);
                    chk("release_mux_hold", 32'(bus.mux_select), 32'(e.idx));
                    chk("draw_timeout", 32'(bus.draw_timeout), 32'(e.to));
                    @(negedge clk);
                    chk("idle_busy", 32'(bus.busy), 32'd0);
                    chk("idle_timeout", 32'(bus.draw_timeout), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [4:0] mask;
        logic [4:0] rem;
        int         idx;
        int         g;
        exp_t       e;
        total    = 0;
        bad      = 0;
        mon_on   = 1'b0;
        m_rr_pac = 1'b0;
        dcnt     = 0;
        last_rel = 0;
        for (int i = 0; i < 5; i++) len[i] = 1;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        #1;
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_mux", 32'(bus.mux_select), 32'd0);
        chk("reset_plot", 32'(bus.plot), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_timeout", 32'(bus.draw_timeout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        tick();

        for (int b = 0; b < c_BATCHES; b++) begin
            wait_idle();
            mask = 5'($urandom_range(1, 31));
            if (b < 3) mask = 5'b00011;
            else if (b < 6) mask = 5'b00010;
            for (int i = 0; i < 5; i++) len[i] = $urandom_range(1, 12);
            rem = mask;
            for (int k = 0; rem != '0; k++) begin
                model_pick(rem, idx);
                rem[idx] = 1'b0;
                e.idx    = idx;
`ifdef DRAW_WATCHDOG_EN
                e.to     = (len[idx] > c_MAX);
                e.plot_n = e.to ? c_MAX : len[idx];
`else
                e.to     = 1'b0;
                e.plot_n = len[idx];
`endif
                e.t_req  = (k == 0) ? cyc : -1;
                q.push_back(e);
            end
            bus.req = mask;
        end
        wait_idle();
        repeat (3) tick();

        // Asynchronous reset while gameover is drawing
        mon_on = 1'b0;
        len[3] = 1000;
        bus.req = 5'b01000;
        g = 0;
        while (!bus.plot && g < 20) begin
            tick();
            g++;
        end
        chk("gameover_plot_before_reset", 32'(bus.plot), 32'd1);
        chk("gameover_grant_before_reset", 32'(bus.grant), 32'b01000);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_grant", 32'(bus.grant), 32'd0);
        chk("async_reset_mux", 32'(bus.mux_select), 32'd0);
        chk("async_reset_plot", 32'(bus.plot), 32'd0);
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        bus.req  = '0;
        bus.done = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_rr_pac = 1'b0;
        len[0]   = 2;
        len[1]   = 2;
        tick();
        bus.req = 5'b00011;
        tick();
        chk("post_reset_grant_bg", 32'(bus.grant), 32'b00001);
        chk("post_reset_mux", 32'(bus.mux_select), 32'd0);
        chk("post_reset_settle_plot", 32'(bus.plot), 32'd0);
        tick();
        chk("post_reset_draw_plot", 32'(bus.plot), 32'd1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
